// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and encodings for the memory-port arbiter that splits the
// physical-memory line port between the I-cache and D-cache miss paths.
package mem_port_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF  = 32;
   localparam int LINE_WIDTH_DEF  = 256;
   localparam int OFFSET_BITS_DEF = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } arb_op_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that forwards one I-cache or D-cache line transaction
// at a time to physical memory and routes the completion back to its owner.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
   parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
   output logic                  icache_pmem_resp,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
   output logic                  dcache_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic [1:0]            o_dbg_state
);

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   arb_op_t               r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic                  r_last_grant;
   logic                  w_i_req;
   logic                  w_d_req;
   logic                  w_grant_i;
   logic                  w_grant_d;

   assign w_i_req = icache_pmem_read;
   assign w_d_req = dcache_pmem_read | dcache_pmem_write;

   always_comb begin
      w_next_state = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      case (r_state)
         IDLE: begin
            // On contention the side opposite the previous winner goes first.
            if (w_i_req && (!w_d_req || r_last_grant)) begin
               w_grant_i    = 1'b1;
               w_next_state = SERVE_I;
            end else if (w_d_req) begin
               w_grant_d    = 1'b1;
               w_next_state = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op         <= OP_READ;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_next_state;
         if (w_grant_i) begin
            r_op         <= OP_READ;
            r_addr       <= icache_pmem_address & LINE_MASK;
            r_wdata      <= '0;
            r_last_grant <= 1'b0;
         end else if (w_grant_d) begin
            // A simultaneous read and write from the D-cache resolves to the write.
            r_op         <= dcache_pmem_write ? OP_WRITE : OP_READ;
            r_addr       <= dcache_pmem_address & LINE_MASK;
            r_wdata      <= dcache_pmem_wdata;
            r_last_grant <= 1'b1;
         end
      end
   end

   always_comb begin
      pmem_read         = (r_state != IDLE) && (r_op == OP_READ);
      pmem_write        = (r_state != IDLE) && (r_op == OP_WRITE);
      pmem_address      = r_addr;
      pmem_wdata        = r_wdata;
      icache_pmem_resp  = (r_state == SERVE_I) && pmem_resp;
      dcache_pmem_resp  = (r_state == SERVE_D) && pmem_resp;
      icache_pmem_rdata = (r_state == SERVE_I) ? pmem_rdata : '0;
      dcache_pmem_rdata = (r_state == SERVE_D) ? pmem_rdata : '0;
      o_dbg_state       = r_state;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(dcache_pmem_read && dcache_pmem_write))
         else $warning("dcache read and write asserted together; treated as write");
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic         clk;
   logic         rst;
   logic         icache_pmem_read;
   logic [31:0]  icache_pmem_address;
   logic [255:0] icache_pmem_rdata;
   logic         icache_pmem_resp;
   logic         dcache_pmem_read;
   logic         dcache_pmem_write;
   logic [31:0]  dcache_pmem_address;
   logic [255:0] dcache_pmem_wdata;
   logic [255:0] dcache_pmem_rdata;
   logic         dcache_pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [1:0]   o_dbg_state;

   int n_vec;
   int n_fail;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_P  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] PAT_3C = {32{8'h3C}};
   localparam logic [255:0] PAT_Q  = {16{16'h1357}};

   mem_port_arbiter dut (
      .clk                 (clk),
      .rst                 (rst),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .icache_pmem_resp    (icache_pmem_resp),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .pmem_read           (pmem_read),
      .pmem_write          (pmem_write),
      .pmem_address        (pmem_address),
      .pmem_wdata          (pmem_wdata),
      .pmem_rdata          (pmem_rdata),
      .pmem_resp           (pmem_resp),
      .o_dbg_state         (o_dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_vec               = 0;
      n_fail              = 0;
      rst                 = 1'b1;
      icache_pmem_read    = 1'b0;
      icache_pmem_address = '0;
      dcache_pmem_read    = 1'b0;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = '0;
      dcache_pmem_wdata   = '0;
      pmem_rdata          = '0;
      pmem_resp           = 1'b0;

      // Reset state
      do_reset();
      chk("rst_state", o_dbg_state, IDLE);
      chk("rst_pread", pmem_read, 1'b0);
      chk("rst_pwrite", pmem_write, 1'b0);
      chk("rst_paddr", pmem_address, 32'h0);
      chk("rst_pwdata", pmem_wdata, 256'h0);
      chk("rst_iresp", icache_pmem_resp, 1'b0);
      chk("rst_dresp", dcache_pmem_resp, 1'b0);

      // pmem_resp while idle is ignored
      pmem_resp = 1'b1;
      settle();
      chk("idle_resp_i", icache_pmem_resp, 1'b0);
      chk("idle_resp_d", dcache_pmem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0;
      chk("idle_resp_state", o_dbg_state, IDLE);

      // I-read alone
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 32'h0000_1234;
      tick();
      chk("iread_state", o_dbg_state, SERVE_I);
      chk("iread_pread", pmem_read, 1'b1);
      chk("iread_pwrite", pmem_write, 1'b0);
      chk("iread_paddr", pmem_address, 32'h0000_1220);
      pmem_rdata = PAT_A5;
      pmem_resp  = 1'b1;
      settle();
      chk("iread_iresp", icache_pmem_resp, 1'b1);
      chk("iread_irdata", icache_pmem_rdata, PAT_A5);
      chk("iread_dresp", dcache_pmem_resp, 1'b0);
      icache_pmem_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
      settle();
      chk("iread_done_state", o_dbg_state, IDLE);
      chk("iread_done_pread", pmem_read, 1'b0);
      chk("iread_done_iresp", icache_pmem_resp, 1'b0);

      // D-write alone, wdata stable while memory is busy
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 32'h8000_0040;
      dcache_pmem_wdata   = PAT_P;
      tick();
      chk("dwr_state", o_dbg_state, SERVE_D);
      chk("dwr_pwrite", pmem_write, 1'b1);
      chk("dwr_pread", pmem_read, 1'b0);
      chk("dwr_paddr", pmem_address, 32'h8000_0040);
      dcache_pmem_wdata = PAT_Q;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dwr_pwdata_hold", pmem_wdata, PAT_P);
         chk("dwr_dresp_low", dcache_pmem_resp, 1'b0);
      end
      pmem_resp = 1'b1;
      settle();
      chk("dwr_dresp", dcache_pmem_resp, 1'b1);
      chk("dwr_iresp", icache_pmem_resp, 1'b0);
      dcache_pmem_write = 1'b0;
      tick();
      pmem_resp = 1'b0;
      settle();
      chk("dwr_done_dresp", dcache_pmem_resp, 1'b0);
      chk("dwr_done_pwrite", pmem_write, 1'b0);

      // Contention right after reset: I first, then D, then D wins the re-contention
      do_reset();
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 32'h0000_4444;
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 32'h0000_8888;
      tick();
      chk("cont1_state", o_dbg_state, SERVE_I);
      chk("cont1_paddr", pmem_address, 32'h0000_4440);
      pmem_rdata = PAT_3C;
      pmem_resp  = 1'b1;
      settle();
      chk("cont1_iresp", icache_pmem_resp, 1'b1);
      chk("cont1_dresp", dcache_pmem_resp, 1'b0);
      icache_pmem_address = 32'h0000_5555;
      tick();
      pmem_resp = 1'b0;
      chk("cont_bubble_state", o_dbg_state, IDLE);
      chk("cont_bubble_pread", pmem_read, 1'b0);
      tick();
      chk("cont2_state", o_dbg_state, SERVE_D);
      chk("cont2_paddr", pmem_address, 32'h0000_8880);
      chk("cont2_pread", pmem_read, 1'b1);
      pmem_resp = 1'b1;
      settle();
      chk("cont2_dresp", dcache_pmem_resp, 1'b1);
      chk("cont2_drdata", dcache_pmem_rdata, PAT_3C);
      chk("cont2_iresp", icache_pmem_resp, 1'b0);
      dcache_pmem_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
      tick();
      chk("cont3_state", o_dbg_state, SERVE_I);
      chk("cont3_paddr", pmem_address, 32'h0000_5540);
      pmem_resp = 1'b1;
      icache_pmem_read = 1'b0;
      tick();
      pmem_resp = 1'b0;

      // Long latency with D address changing mid-transaction
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 32'h0000_2000;
      tick();
      chk("long_state", o_dbg_state, SERVE_D);
      for (int i = 0; i < 20; i++) begin
         dcache_pmem_address = $urandom_range(32'h7FFF_FFFF, 0);
         tick();
         chk("long_paddr", pmem_address, 32'h0000_2000);
         chk("long_dresp_low", dcache_pmem_resp, 1'b0);
      end
      pmem_rdata = PAT_Q;
      pmem_resp  = 1'b1;
      settle();
      chk("long_dresp", dcache_pmem_resp, 1'b1);
      chk("long_drdata", dcache_pmem_rdata, PAT_Q);
      dcache_pmem_read = 1'b0;
      tick();
      pmem_resp = 1'b0;

      // Reset during SERVE_D abandons the write
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 32'h0000_0F00;
      dcache_pmem_wdata   = PAT_P;
      tick();
      chk("rstmid_pwrite_before", pmem_write, 1'b1);
      rst = 1'b1;
      tick();
      chk("rstmid_pwrite", pmem_write, 1'b0);
      chk("rstmid_dresp", dcache_pmem_resp, 1'b0);
      chk("rstmid_state", o_dbg_state, IDLE);
      chk("rstmid_paddr", pmem_address, 32'h0);
      rst               = 1'b0;
      dcache_pmem_write = 1'b0;
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 32'h0000_ABCD;
      tick();
      chk("rstmid_next_state", o_dbg_state, SERVE_I);
      chk("rstmid_next_paddr", pmem_address, 32'h0000_ABC0);
      pmem_resp = 1'b1;
      settle();
      chk("rstmid_next_iresp", icache_pmem_resp, 1'b1);
      icache_pmem_read = 1'b0;
      tick();
      pmem_resp = 1'b0;

      // D read and write together resolve to a write
      dcache_pmem_read    = 1'b1;
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 32'h0000_0060;
      dcache_pmem_wdata   = PAT_3C;
      tick();
      chk("rw_pwrite", pmem_write, 1'b1);
      chk("rw_pread", pmem_read, 1'b0);
      chk("rw_pwdata", pmem_wdata, PAT_3C);
      dcache_pmem_read  = 1'b0;
      pmem_resp = 1'b1;
      settle();
      chk("rw_dresp", dcache_pmem_resp, 1'b1);
      dcache_pmem_write = 1'b0;
      tick();
      pmem_resp = 1'b0;
      settle();
      chk("rw_done_state", o_dbg_state, IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
